// File: rtl/dbg_step_ctrl.sv
// Debug single-step / run controller generating a registered CPU step clock with PC breakpoints.
// Define DBG_CYCLE_CNT_EN to build the 32-bit clk_cpu pulse counter on cyc_cnt.
module dbg_step_ctrl #(
  parameter int NUM_BP = 4,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [3:0]      cmd_idx,
  input  logic [PC_W-1:0] cmd_arg,
  input  logic            halt_req,
  input  logic [PC_W-1:0] pc_chk,
  output logic            clk_cpu,
  output logic            busy,
  output logic            bp_hit,
  output logic [3:0]      bp_idx,
  output logic [31:0]     cyc_cnt
);

  localparam logic [2:0] OP_STEP    = 3'd1;
  localparam logic [2:0] OP_RUN     = 3'd2;
  localparam logic [2:0] OP_SET_BP  = 3'd3;
  localparam logic [2:0] OP_CLR_BP  = 3'd4;
  localparam logic [2:0] OP_CLR_ALL = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

  state_t            state_q, state_d;
  logic              clk_cpu_q, clk_cpu_d;
  logic              busy_q, busy_d;
  logic              bp_hit_q, bp_hit_d;
  logic [3:0]        bp_idx_q, bp_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step_mode_q, step_mode_d;
  logic              halt_pend_q, halt_pend_d;
  logic [PC_W-1:0]   bp_addr_q [NUM_BP];
  logic [PC_W-1:0]   bp_addr_d [NUM_BP];
  logic [NUM_BP-1:0] bp_en_q, bp_en_d;
  logic [NUM_BP-1:0] bp_match;
  logic              hit_any;
  logic [3:0]        hit_idx;
  logic              cmd_acc;
  logic              stop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BP; gi++) begin : g_cmp
      assign bp_match[gi] = bp_en_q[gi] && (bp_addr_q[gi] == pc_chk);
    end
  endgenerate

  // Scan downwards so the lowest matching index wins.
  always_comb begin
    hit_any = |bp_match;
    hit_idx = 4'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_match[i]) hit_idx = 4'(i);
    end
  end

  assign cmd_acc = cmd_valid && (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    bp_hit_d    = bp_hit_q;
    bp_idx_d    = bp_idx_q;
    cnt_d       = cnt_q;
    step_mode_d = step_mode_q;
    halt_pend_d = halt_pend_q;
    bp_addr_d   = bp_addr_q;
    bp_en_d     = bp_en_q;
    stop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        halt_pend_d = 1'b0;
        if (cmd_acc) begin
          if (cmd_op >= OP_STEP && cmd_op <= OP_CLR_ALL) bp_hit_d = 1'b0;
          case (cmd_op)
            OP_STEP: begin
              cnt_d       = (cmd_arg[CNT_W-1:0] == '0) ? CNT_W'(1) : cmd_arg[CNT_W-1:0];
              step_mode_d = 1'b1;
              state_d     = S_HI;
            end
            OP_RUN: begin
              step_mode_d = 1'b0;
              state_d     = S_HI;
            end
            OP_SET_BP: begin
              for (int i = 0; i < NUM_BP; i++) begin
                if (cmd_idx == 4'(i)) begin
                  bp_addr_d[i] = cmd_arg;
                  bp_en_d[i]   = 1'b1;
                end
              end
            end
            OP_CLR_BP: begin
              for (int i = 0; i < NUM_BP; i++) begin
                if (cmd_idx == 4'(i)) bp_en_d[i] = 1'b0;
              end
            end
            OP_CLR_ALL: bp_en_d = '0;
            default: ;
          endcase
        end
      end
      S_HI: begin
        // A halt seen mid-pulse is held so the following LO still stops.
        if (halt_req) halt_pend_d = 1'b1;
        state_d = S_LO;
      end
      S_LO: begin
        stop = hit_any || halt_req || halt_pend_q || (step_mode_q && cnt_q == CNT_W'(1));
        if (hit_any) begin
          bp_hit_d = 1'b1;
          bp_idx_d = hit_idx;
        end
        if (stop) begin
          state_d     = S_IDLE;
          halt_pend_d = 1'b0;
        end else begin
          state_d = S_HI;
          if (step_mode_q) cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    clk_cpu_d = (state_d == S_HI);
    busy_d    = (state_d == S_HI) || (state_d == S_LO);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      clk_cpu_q   <= 1'b0;
      busy_q      <= 1'b0;
      bp_hit_q    <= 1'b0;
      bp_idx_q    <= 4'd0;
      cnt_q       <= '0;
      step_mode_q <= 1'b0;
      halt_pend_q <= 1'b0;
      bp_en_q     <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      clk_cpu_q   <= clk_cpu_d;
      busy_q      <= busy_d;
      bp_hit_q    <= bp_hit_d;
      bp_idx_q    <= bp_idx_d;
      cnt_q       <= cnt_d;
      step_mode_q <= step_mode_d;
      halt_pend_q <= halt_pend_d;
      bp_en_q     <= bp_en_d;
      bp_addr_q   <= bp_addr_d;
    end
  end

`ifdef DBG_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  // HI is only ever entered from IDLE or LO, so every HI next-state is an entry.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (state_d == S_HI) cyc_cnt_d = cyc_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cyc_cnt_q <= 32'd0;
    else       cyc_cnt_q <= cyc_cnt_d;
  end

  assign cyc_cnt = cyc_cnt_q;
`else
  assign cyc_cnt = 32'd0;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign clk_cpu   = clk_cpu_q;
  assign busy      = busy_q;
  assign bp_hit    = bp_hit_q;
  assign bp_idx    = bp_idx_q;

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Directed testbench for dbg_step_ctrl: stepping, run-to-breakpoint, halt and reset behaviour.
module tb_dbg_step_ctrl;

  localparam logic [2:0] OP_NOP = 3'd0, OP_STEP = 3'd1, OP_RUN = 3'd2;
  localparam logic [2:0] OP_SET = 3'd3, OP_CLR = 3'd4, OP_CLRALL = 3'd5;
`ifdef DBG_CYCLE_CNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [3:0]  cmd_idx = 4'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        halt_req = 1'b0;
  logic [31:0] pc_chk;
  logic        clk_cpu, busy, bp_hit;
  logic [3:0]  bp_idx;
  logic [31:0] cyc_cnt;

  int          checks = 0;
  int          failures = 0;
  int          pulse_total = 0;
  int          pulse_start = 0;
  logic [31:0] pc_base = 32'd0;
  bit          pc_adv = 1'b0;
  int          pulses;
  logic [31:0] exp_cyc = 32'd0;

  always #5 clk = ~clk;

  // CPU model: PC advances by 4 on each step pulse when enabled.
  always @(posedge clk_cpu) pulse_total++;
  assign pulses = pulse_total - pulse_start;
  assign pc_chk = pc_base + (pc_adv ? 32'(pulses * 4) : 32'd0);

  dbg_step_ctrl #(.NUM_BP(4), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .halt_req(halt_req),
    .pc_chk(pc_chk), .clk_cpu(clk_cpu), .busy(busy), .bp_hit(bp_hit),
    .bp_idx(bp_idx), .cyc_cnt(cyc_cnt)
  );

  task automatic issue_cmd(input logic [2:0] op, input logic [3:0] idx, input logic [31:0] arg);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    $display("cmd op=%0d idx=%0d arg=%0h ready_after=%0b busy=%0b", op, idx, arg, cmd_ready, busy);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (clk_cpu !== 1'b0) begin failures++; $display("FAIL reset_clk_cpu: got %0b expected 0", clk_cpu); end
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL reset_bp_hit: got %0b expected 0", bp_hit); end
    checks++; if (bp_idx !== 4'd0) begin failures++; $display("FAIL reset_bp_idx: got %0d expected 0", bp_idx); end
    checks++; if (cyc_cnt !== 32'd0) begin failures++; $display("FAIL reset_cyc_cnt: got %0d expected 0", cyc_cnt); end
  endtask

  task automatic test_step3();
    logic [7:0] pat, bsy;
    pc_base = 32'h100; pc_adv = 1'b0; pulse_start = pulse_total;
    issue_cmd(OP_STEP, 4'd0, 32'd3);
    for (int i = 0; i < 8; i++) begin
      pat[7-i] = clk_cpu; bsy[7-i] = busy;
      @(negedge clk);
    end
    exp_cyc = exp_cyc + 32'd3;
    $display("step3 clk_cpu=%b busy=%b pulses=%0d", pat, bsy, pulses);
    checks++; if (pat !== 8'b10101000) begin failures++; $display("FAIL step3_pattern: got %b expected 10101000", pat); end
    checks++; if (bsy !== 8'b11111100) begin failures++; $display("FAIL step3_busy: got %b expected 11111100", bsy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL step3_ready: got %0b expected 1", cmd_ready); end
    checks++; if (pulses !== 3) begin failures++; $display("FAIL step3_pulses: got %0d expected 3", pulses); end
    checks++; if (cyc_cnt !== (CYC_EN ? exp_cyc : 32'd0)) begin failures++; $display("FAIL step3_cyc_cnt: got %0d expected %0d", cyc_cnt, CYC_EN ? exp_cyc : 32'd0); end
  endtask

  task automatic test_run_bp();
    bit ok;
    issue_cmd(OP_SET, 4'd2, 32'h10);
    pc_base = 32'h0; pc_adv = 1'b1; pulse_start = pulse_total;
    issue_cmd(OP_RUN, 4'd0, 32'd0);
    wait_idle(100, ok);
    exp_cyc = exp_cyc + 32'd4;
    $display("run_bp pulses=%0d pc=%0h bp_hit=%0b bp_idx=%0d", pulses, pc_chk, bp_hit, bp_idx);
    checks++; if (!ok) begin failures++; $display("FAIL run_bp_timeout: got busy=1 expected busy=0 within 100 cycles"); end
    checks++; if (pulses !== 4) begin failures++; $display("FAIL run_bp_pulses: got %0d expected 4", pulses); end
    checks++; if (pc_chk !== 32'h10) begin failures++; $display("FAIL run_bp_pc: got %0h expected 10", pc_chk); end
    checks++; if (bp_hit !== 1'b1) begin failures++; $display("FAIL run_bp_hit: got %0b expected 1", bp_hit); end
    checks++; if (bp_idx !== 4'd2) begin failures++; $display("FAIL run_bp_idx: got %0d expected 2", bp_idx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_bp_busy: got %0b expected 0", busy); end
    checks++; if (cyc_cnt !== (CYC_EN ? exp_cyc : 32'd0)) begin failures++; $display("FAIL run_bp_cyc_cnt: got %0d expected %0d", cyc_cnt, CYC_EN ? exp_cyc : 32'd0); end
  endtask

  task automatic test_multi_bp();
    bit ok;
    issue_cmd(OP_SET, 4'd1, 32'h8);
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL set_clears_hit: got %0b expected 0", bp_hit); end
    issue_cmd(OP_SET, 4'd3, 32'h8);
    pc_base = 32'h0; pc_adv = 1'b1; pulse_start = pulse_total;
    issue_cmd(OP_RUN, 4'd0, 32'd0);
    wait_idle(100, ok);
    $display("multi_bp first pulses=%0d bp_idx=%0d", pulses, bp_idx);
    checks++; if (!ok || pulses !== 2) begin failures++; $display("FAIL multi_bp_pulses1: got %0d expected 2", pulses); end
    checks++; if (bp_idx !== 4'd1) begin failures++; $display("FAIL multi_bp_lowest: got %0d expected 1", bp_idx); end
    issue_cmd(OP_CLR, 4'd1, 32'd0);
    pulse_start = pulse_total;
    issue_cmd(OP_RUN, 4'd0, 32'd0);
    wait_idle(100, ok);
    exp_cyc = exp_cyc + 32'd4;
    $display("multi_bp second pulses=%0d bp_idx=%0d", pulses, bp_idx);
    checks++; if (!ok || pulses !== 2) begin failures++; $display("FAIL multi_bp_pulses2: got %0d expected 2", pulses); end
    checks++; if (bp_idx !== 4'd3 || bp_hit !== 1'b1) begin failures++; $display("FAIL multi_bp_after_clr: got idx=%0d hit=%0b expected idx=3 hit=1", bp_idx, bp_hit); end
  endtask

  task automatic test_halt();
    bit ok;
    issue_cmd(OP_NOP, 4'd0, 32'd0);
    checks++; if (bp_hit !== 1'b1) begin failures++; $display("FAIL nop_keeps_hit: got %0b expected 1", bp_hit); end
    issue_cmd(3'd6, 4'd0, 32'd0);
    checks++; if (bp_hit !== 1'b1 || cmd_ready !== 1'b1) begin failures++; $display("FAIL op6_nop: got hit=%0b ready=%0b expected hit=1 ready=1", bp_hit, cmd_ready); end
    issue_cmd(OP_CLRALL, 4'd0, 32'd0);
    pc_base = 32'h0; pc_adv = 1'b1; pulse_start = pulse_total;
    issue_cmd(OP_RUN, 4'd0, 32'd0);
    checks++; if (clk_cpu !== 1'b1) begin failures++; $display("FAIL halt_in_hi: got clk_cpu=%0b expected 1", clk_cpu); end
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    @(negedge clk);
    exp_cyc = exp_cyc + 32'd1;
    $display("halt busy=%0b ready=%0b bp_hit=%0b pulses=%0d", busy, cmd_ready, bp_hit, pulses);
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL halt_stop: got busy=%0b ready=%0b expected busy=0 ready=1", busy, cmd_ready); end
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL halt_bp_hit: got %0b expected 0", bp_hit); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL halt_pulses: got %0d expected 1", pulses); end
    halt_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || clk_cpu !== 1'b0) begin failures++; $display("FAIL halt_idle_ignored: got busy=%0b clk_cpu=%0b expected 0 0", busy, clk_cpu); end
    halt_req = 1'b0;
    pulse_start = pulse_total;
    issue_cmd(OP_STEP, 4'd0, 32'd0);
    wait_idle(50, ok);
    exp_cyc = exp_cyc + 32'd1;
    checks++; if (!ok || pulses !== 1) begin failures++; $display("FAIL step0_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_bp_at_start();
    bit ok;
    issue_cmd(OP_SET, 4'd0, 32'h10);
    pc_base = 32'h10; pc_adv = 1'b0; pulse_start = pulse_total;
    issue_cmd(OP_RUN, 4'd0, 32'd0);
    wait_idle(50, ok);
    exp_cyc = exp_cyc + 32'd1;
    $display("bp_at_start pulses=%0d bp_hit=%0b bp_idx=%0d", pulses, bp_hit, bp_idx);
    checks++; if (!ok || pulses !== 1) begin failures++; $display("FAIL bp_start_pulses: got %0d expected 1", pulses); end
    checks++; if (bp_hit !== 1'b1 || bp_idx !== 4'd0) begin failures++; $display("FAIL bp_start_hit: got hit=%0b idx=%0d expected hit=1 idx=0", bp_hit, bp_idx); end
    issue_cmd(OP_SET, 4'd7, 32'h20);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL set_idx7_accept: got ready=%0b busy=%0b expected 1 0", cmd_ready, busy); end
    pc_base = 32'h20; pulse_start = pulse_total;
    issue_cmd(OP_STEP, 4'd0, 32'd3);
    wait_idle(50, ok);
    exp_cyc = exp_cyc + 32'd3;
    $display("set_idx7 step pulses=%0d bp_hit=%0b", pulses, bp_hit);
    checks++; if (!ok || pulses !== 3 || bp_hit !== 1'b0) begin failures++; $display("FAIL set_idx7_ignored: got pulses=%0d hit=%0b expected pulses=3 hit=0", pulses, bp_hit); end
    checks++; if (cyc_cnt !== (CYC_EN ? exp_cyc : 32'd0)) begin failures++; $display("FAIL cyc_cnt_total: got %0d expected %0d", cyc_cnt, CYC_EN ? exp_cyc : 32'd0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    issue_cmd(OP_SET, 4'd0, 32'h30);
    pc_base = 32'h40; pc_adv = 1'b0;
    issue_cmd(OP_RUN, 4'd0, 32'd0);
    checks++; if (clk_cpu !== 1'b1) begin failures++; $display("FAIL rst_mid_in_hi: got clk_cpu=%0b expected 1", clk_cpu); end
    rstn = 1'b0;
    #1;
    $display("reset_mid clk_cpu=%0b busy=%0b ready=%0b cyc=%0d", clk_cpu, busy, cmd_ready, cyc_cnt);
    checks++; if (clk_cpu !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_async: got clk_cpu=%0b busy=%0b expected 0 0", clk_cpu, busy); end
    checks++; if (cmd_ready !== 1'b1 || cyc_cnt !== 32'd0) begin failures++; $display("FAIL rst_mid_state: got ready=%0b cyc=%0d expected 1 0", cmd_ready, cyc_cnt); end
    @(negedge clk);
    rstn = 1'b1;
    pc_base = 32'h30; pulse_start = pulse_total;
    issue_cmd(OP_RUN, 4'd0, 32'd0);
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1 || pulses < 5) begin failures++; $display("FAIL rst_bp_cleared: got busy=%0b pulses=%0d expected busy=1 pulses>=5", busy, pulses); end
    halt_req = 1'b1;
    wait_idle(10, ok);
    halt_req = 1'b0;
    $display("reset_mid rerun stopped=%0b pulses=%0d bp_hit=%0b", ok, pulses, bp_hit);
    checks++; if (!ok || bp_hit !== 1'b0) begin failures++; $display("FAIL rst_halt_stop: got stopped=%0b hit=%0b expected 1 0", ok, bp_hit); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_step3();
    test_run_bp();
    test_multi_bp();
    test_halt();
    test_bp_at_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
